digit_entry_ctrl: RTL and testbench

//  Sequences the 4-bit-per-digit hex entry shift register from board buttons.

---
 rtl/digit_entry_ctrl_pkg.sv | 20 ++
 rtl/digit_entry_ctrl_debounce.sv | 49 ++++
 rtl/digit_entry_ctrl.sv | 148 ++++++++++++++
 tb/tb_digit_entry_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/digit_entry_ctrl_pkg.sv
// Shared constants and FSM encoding for the hex digit entry controller and its display logic.
package digit_entry_ctrl_pkg;

    localparam int DIGIT_W    = 4;
    localparam int MAX_DIGITS = 8;
    localparam int NUMB_W     = DIGIT_W * MAX_DIGITS;

    localparam int NUM_BTNS   = 3;
    localparam int BTN_ENTER  = 0;
    localparam int BTN_CLEAR  = 1;
    localparam int BTN_COMMIT = 2;

    typedef enum logic [1:0] {
        ENTRY_A = 2'd0,
        ENTRY_B = 2'd1,
        CAPTURE = 2'd2,
        READY   = 2'd3
    } state_t;

endpackage

// File: rtl/digit_entry_ctrl_debounce.sv
// Button debouncer: 2-FF synchroniser, stable-count filter, single-cycle pulse on each accepted press.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic level,
    output logic rise_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1_reg;
    logic             sync2_reg;
    logic             level_reg;
    logic             pulse_reg;
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            level_reg <= 1'b0;
            pulse_reg <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= btn_in;
            sync2_reg <= sync1_reg;
            pulse_reg <= 1'b0;
            // Any cycle where the input agrees with the level restarts the stability count.
            if (sync2_reg != level_reg) begin
                if (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    level_reg <= ~level_reg;
                    pulse_reg <= ~level_reg;
                    cnt_reg   <= '0;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end else begin
                cnt_reg <= '0;
            end
        end
    end

    assign level      = level_reg;
    assign rise_pulse = pulse_reg;

endmodule

// File: rtl/digit_entry_ctrl.sv
// Sequences hex digit entry into the external shift register and captures operands A then B.
module digit_entry_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int MAX_DIGITS      = digit_entry_ctrl_pkg::MAX_DIGITS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_enter,
    input  logic        btn_clear,
    input  logic        btn_commit,
    input  logic [31:0] NUMB,
    output logic        sr_enter,
    output logic        sr_reset,
    output logic [3:0]  digit_cnt,
    output logic        overflow,
    output logic [31:0] opnd_a,
    output logic [31:0] opnd_b,
    output logic        operands_valid,
    output logic [1:0]  state_o
);

    import digit_entry_ctrl_pkg::*;

    logic [NUM_BTNS-1:0] btns;
    logic [NUM_BTNS-1:0] pulses;
    logic [NUM_BTNS-1:0] levels;
    logic                levels_unused;

    assign btns = {btn_commit, btn_clear, btn_enter};

    generate
        for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_db
            btn_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_db (
                .clk       (clk),
                .reset     (reset),
                .btn_in    (btns[gi]),
                .level     (levels[gi]),
                .rise_pulse(pulses[gi])
            );
        end
    endgenerate

    // Debounced levels are only of interest to display logic, not to this FSM.
    assign levels_unused = ^levels;

    state_t      state_reg, state_next;
    logic        cap_sel_reg, cap_sel_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic        ovf_reg, ovf_next;
    logic [31:0] a_reg, a_next;
    logic [31:0] b_reg, b_next;
    logic        valid_reg, valid_next;
    logic        sr_enter_reg, sr_enter_next;
    logic        sr_reset_reg, sr_reset_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ENTRY_A;
            cap_sel_reg  <= 1'b0;
            cnt_reg      <= '0;
            ovf_reg      <= 1'b0;
            a_reg        <= '0;
            b_reg        <= '0;
            valid_reg    <= 1'b0;
            sr_enter_reg <= 1'b0;
            sr_reset_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cap_sel_reg  <= cap_sel_next;
            cnt_reg      <= cnt_next;
            ovf_reg      <= ovf_next;
            a_reg        <= a_next;
            b_reg        <= b_next;
            valid_reg    <= valid_next;
            sr_enter_reg <= sr_enter_next;
            sr_reset_reg <= sr_reset_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cap_sel_next  = cap_sel_reg;
        cnt_next      = cnt_reg;
        ovf_next      = ovf_reg;
        a_next        = a_reg;
        b_next        = b_reg;
        valid_next    = valid_reg;
        sr_enter_next = 1'b0;
        sr_reset_next = 1'b0;
        case (state_reg)
            ENTRY_A, ENTRY_B: begin
                if (pulses[BTN_CLEAR]) begin
                    sr_reset_next = 1'b1;
                    cnt_next      = '0;
                    ovf_next      = 1'b0;
                end else if (pulses[BTN_COMMIT]) begin
                    // A commit racing an in-flight enter strobe would capture a stale NUMB.
                    if (!sr_enter_reg) begin
                        state_next   = CAPTURE;
                        cap_sel_next = (state_reg == ENTRY_B);
                    end
                end else if (pulses[BTN_ENTER]) begin
                    if (cnt_reg < 4'(MAX_DIGITS)) begin
                        sr_enter_next = 1'b1;
                        cnt_next      = cnt_reg + 4'd1;
                    end else begin
                        ovf_next = 1'b1;
                    end
                end
            end
            CAPTURE: begin
                sr_reset_next = 1'b1;
                cnt_next      = '0;
                ovf_next      = 1'b0;
                if (cap_sel_reg) begin
                    b_next     = NUMB;
                    valid_next = 1'b1;
                    state_next = READY;
                end else begin
                    a_next     = NUMB;
                    state_next = ENTRY_B;
                end
            end
            READY: begin
                if (pulses[BTN_CLEAR]) begin
                    a_next        = '0;
                    b_next        = '0;
                    valid_next    = 1'b0;
                    sr_reset_next = 1'b1;
                    state_next    = ENTRY_A;
                end
            end
            default: state_next = ENTRY_A;
        endcase
    end

    assign sr_enter       = sr_enter_reg;
    assign sr_reset       = sr_reset_reg;
    assign digit_cnt      = cnt_reg;
    assign overflow       = ovf_reg;
    assign opnd_a         = a_reg;
    assign opnd_b         = b_reg;
    assign operands_valid = valid_reg;
    assign state_o        = state_reg;

endmodule

// File: tb/tb_digit_entry_ctrl.sv
// Bench for digit_entry_ctrl: attached shift register model plus a press-level reference model.
module tb_digit_entry_ctrl;

    localparam int DB    = 4;
    localparam int MAXD  = 8;
    localparam int S_A   = 0;
    localparam int S_B   = 1;
    localparam int S_CAP = 2;
    localparam int S_RDY = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        btn_enter = 1'b0;
    logic        btn_clear = 1'b0;
    logic        btn_commit = 1'b0;
    logic [31:0] numb = '0;
    logic [3:0]  sw = '0;
    logic        sr_enter, sr_reset, overflow, operands_valid;
    logic [3:0]  digit_cnt;
    logic [31:0] opnd_a, opnd_b;
    logic [1:0]  state_o;

    digit_entry_ctrl #(.DEBOUNCE_CYCLES(DB), .MAX_DIGITS(MAXD)) dut (
        .clk(clk), .reset(reset), .btn_enter(btn_enter), .btn_clear(btn_clear),
        .btn_commit(btn_commit), .NUMB(numb), .sr_enter(sr_enter), .sr_reset(sr_reset),
        .digit_cnt(digit_cnt), .overflow(overflow), .opnd_a(opnd_a), .opnd_b(opnd_b),
        .operands_valid(operands_valid), .state_o(state_o)
    );

    always #5 clk = ~clk;

    // Shift register attached to the controller.
    always @(posedge clk) begin
        if (reset || sr_reset) numb <= '0;
        else if (sr_enter)     numb <= {numb[27:0], sw};
    end

    int n_ent = 0, n_rst = 0, n_both = 0;
    always @(negedge clk) begin
        if (sr_enter) n_ent++;
        if (sr_reset) n_rst++;
        if (sr_enter && sr_reset) n_both++;
    end

    int checks = 0, failures = 0;
    int base_ent, base_rst;

    // Reference model: operand entry at the level of whole button presses.
    int          m_state;
    logic [3:0]  m_dig[$];
    bit          m_ovf, m_valid;
    logic [31:0] m_a, m_b;
    int          e_ent, e_rst;

    function automatic logic [31:0] digits_value();
        logic [31:0] v = '0;
        foreach (m_dig[i]) v = (v << 4) | 32'(m_dig[i]);
        return v;
    endfunction

    task automatic model_reset();
        m_state = S_A; m_dig.delete(); m_ovf = 0; m_valid = 0; m_a = '0; m_b = '0;
        e_ent = 0; e_rst = 0;
    endtask

    task automatic model_apply(input bit e, input bit c, input bit m, input logic [3:0] d);
        e_ent = 0; e_rst = 0;
        if (m_state == S_A || m_state == S_B) begin
            if (c) begin
                m_dig.delete(); m_ovf = 0; e_rst = 1;
            end else if (m) begin
                if (m_state == S_A) begin m_a = digits_value(); m_state = S_B; end
                else begin m_b = digits_value(); m_state = S_RDY; m_valid = 1; end
                m_dig.delete(); m_ovf = 0; e_rst = 1;
            end else if (e) begin
                if (m_dig.size() < MAXD) begin m_dig.push_back(d); e_ent = 1; end
                else m_ovf = 1;
            end
        end else if (m_state == S_RDY && c) begin
            m_a = '0; m_b = '0; m_valid = 0; m_state = S_A; e_rst = 1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        $display("txn %-10s state=%0d cnt=%0d ovf=%0d numb=%h a=%h b=%h valid=%0d", tag,
                 state_o, digit_cnt, overflow, numb, opnd_a, opnd_b, operands_valid);
        check({tag, ".state"}, 32'(state_o), 32'(m_state));
        check({tag, ".cnt"}, 32'(digit_cnt), 32'(m_dig.size()));
        check({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
        check({tag, ".numb"}, numb, digits_value());
        check({tag, ".opnd_a"}, opnd_a, m_a);
        check({tag, ".opnd_b"}, opnd_b, m_b);
        check({tag, ".valid"}, 32'(operands_valid), 32'(m_valid));
        check({tag, ".n_sr_enter"}, 32'(n_ent - base_ent), 32'(e_ent));
        check({tag, ".n_sr_reset"}, 32'(n_rst - base_rst), 32'(e_rst));
        check({tag, ".both_strobes"}, 32'(n_both), 32'd0);
    endtask

    task automatic press(input string tag, input bit e, input bit c, input bit m,
                         input logic [3:0] d, input int hold);
        base_ent = n_ent; base_rst = n_rst;
        sw = d;
        btn_enter = e; btn_clear = c; btn_commit = m;
        repeat (hold) @(negedge clk);
        btn_enter = 0; btn_clear = 0; btn_commit = 0;
        repeat (12) @(negedge clk);
        model_apply(e, c, m, d);
        check_all(tag);
    endtask

    initial begin
        model_reset();
        base_ent = 0; base_rst = 0;
        repeat (3) @(negedge clk);
        check_all("reset");
        reset = 0;
        repeat (2) @(negedge clk);

        // Bouncing enter: no run of 4 stable cycles until the final hold.
        base_ent = n_ent; base_rst = n_rst;
        sw = 4'h9;
        for (int i = 0; i < 10; i++) begin
            btn_enter = ~btn_enter;
            repeat (2) @(negedge clk);
        end
        btn_enter = 1;
        repeat (12) @(negedge clk);
        btn_enter = 0;
        repeat (12) @(negedge clk);
        model_apply(1, 0, 0, 4'h9);
        check_all("bounce");
        press("clr", 0, 1, 0, 4'h0, 10);

        press("ent1", 1, 0, 0, 4'h1, 10);
        press("ent2", 1, 0, 0, 4'h2, 10);
        press("ent3", 1, 0, 0, 4'h3, 10);
        press("commitA", 0, 0, 1, 4'h0, 10);
        check("opnd_a_123", opnd_a, 32'h0000_0123);

        for (int i = 0; i < 9; i++) press("entF", 1, 0, 0, 4'hF, 10);
        check("numb_all_F", numb, 32'hFFFF_FFFF);
        check("ovf_after_9", 32'(overflow), 32'd1);
        press("clrF", 0, 1, 0, 4'h0, 10);

        press("commitB0", 0, 0, 1, 4'h0, 10);
        press("clrRdy", 0, 1, 0, 4'h0, 10);
        press("ent5", 1, 0, 0, 4'h5, 10);
        press("commitA5", 0, 0, 1, 4'h0, 10);
        press("entA", 1, 0, 0, 4'hA, 10);
        press("commitBA", 0, 0, 1, 4'h0, 10);
        check("opnd_b_A", opnd_b, 32'h0000_000A);
        check("state_ready", 32'(state_o), 32'(S_RDY));
        press("entRdy", 1, 0, 0, 4'h4, 10);
        press("clrRdy2", 0, 1, 0, 4'h0, 10);

        press("ent+clr", 1, 1, 0, 4'h6, 10);
        press("ent7", 1, 0, 0, 4'h7, 10);
        press("cmt+ent", 1, 0, 1, 4'h8, 10);

        for (int i = 0; i < 60; i++) begin
            int r = int'($urandom_range(9, 0));
            logic [3:0] d = 4'($urandom_range(15, 0));
            int h = int'($urandom_range(16, 9));
            if (r < 6)      press("rnd_ent", 1, 0, 0, d, h);
            else if (r < 8) press("rnd_cmt", 0, 0, 1, d, h);
            else            press("rnd_clr", 0, 1, 0, d, h);
        end

        // Reset landing on the CAPTURE cycle of operand A.
        reset = 1;
        repeat (2) @(negedge clk);
        reset = 0;
        model_reset();
        @(negedge clk);
        press("ent3r", 1, 0, 0, 4'h3, 10);
        btn_commit = 1;
        for (int i = 0; i < 40 && state_o != 2'(S_CAP); i++) @(negedge clk);
        check("capture_seen", 32'(state_o), 32'(S_CAP));
        reset = 1;
        @(negedge clk);
        check("rst_cap.opnd_a", opnd_a, 32'd0);
        check("rst_cap.sr_reset", 32'(sr_reset), 32'd0);
        check("rst_cap.state", 32'(state_o), 32'(S_A));
        btn_commit = 0;
        repeat (3) @(negedge clk);
        reset = 0;
        model_reset();
        base_ent = n_ent; base_rst = n_rst;
        repeat (12) @(negedge clk);
        check_all("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
